// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between instruction fetch (IF, read-only) and
// the memory stage (MEM, read or write). Each accepted request becomes one
// RAM access of RAM_LATENCY cycles, followed by a one-cycle response pulse
// to the requester that won.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to get round-robin
// arbitration on ties. Without it, MEM always beats IF.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_we,
  output logic              mem_rsp_valid,
  output logic [DATA_W-1:0] mem_rsp_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              grant_mem
);

  // A RAM with zero latency cannot be sequenced by this block.
  if (RAM_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: RAM_LATENCY must be >= 1");
  end

  localparam int CNT_W = (RAM_LATENCY < 1) ? 1 : $clog2(RAM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RAM_LATENCY);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(32'd1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_ram_address;
  logic [DATA_W-1:0]   r_ram_data_in;
  logic                r_ram_we;
  logic                r_is_write;
  logic                r_grant_mem;
  logic                r_busy;
  logic                r_if_rsp_valid;
  logic [DATA_W-1:0]   r_if_rsp_data;
  logic                r_mem_rsp_valid;
  logic [DATA_W-1:0]   r_mem_rsp_data;

  logic                w_pick_mem;
  logic                w_idle;
  logic                w_if_ready;
  logic                w_mem_ready;
  logic                w_fire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Who won the most recent handshake; starts as MEM so IF wins the first tie.
  logic                r_last_mem;

  // Remember the last winner so ties alternate between the requesters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_mem <= 1'b1;
    end else if (w_fire) begin
      r_last_mem <= w_pick_mem;
    end else begin
      r_last_mem <= r_last_mem;
    end
  end

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    w_pick_mem = mem_req_valid;
    if (mem_req_valid && if_req_valid) begin
      w_pick_mem = ~r_last_mem;
    end else begin
      w_pick_mem = mem_req_valid;
    end
  end
`else
  // Fixed-priority pick: any MEM request beats IF.
  always_comb begin
    w_pick_mem = mem_req_valid;
  end
`endif

  // Handshake: only the winner sees ready, and only while idle and out of reset.
  always_comb begin
    w_idle      = (r_state == S_IDLE) && rst;
    w_if_ready  = w_idle && if_req_valid && !w_pick_mem;
    w_mem_ready = w_idle && mem_req_valid && w_pick_mem;
    w_fire      = w_if_ready || w_mem_ready;
  end

  // Access sequencer: latch the winner, count the RAM latency, issue the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_ram_address   <= '0;
      r_ram_data_in   <= '0;
      r_ram_we        <= 1'b0;
      r_is_write      <= 1'b0;
      r_grant_mem     <= 1'b0;
      r_busy          <= 1'b0;
      r_if_rsp_valid  <= 1'b0;
      r_if_rsp_data   <= '0;
      r_mem_rsp_valid <= 1'b0;
      r_mem_rsp_data  <= '0;
    end else begin
      // Pulses last a single cycle unless re-asserted below.
      r_ram_we        <= 1'b0;
      r_if_rsp_valid  <= 1'b0;
      r_mem_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_state       <= S_ACCESS;
            r_cnt         <= ONE_C;
            r_busy        <= 1'b1;
            r_grant_mem   <= w_pick_mem;
            r_ram_address <= w_pick_mem ? mem_addr : if_addr;
            r_ram_data_in <= w_pick_mem ? mem_wdata : '0;
            r_ram_we      <= w_pick_mem && mem_we;
            r_is_write    <= w_pick_mem && mem_we;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        S_ACCESS: begin
          if (r_cnt == LAT_C) begin
            // Last latency cycle: RAM data is valid now, response goes out next cycle.
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            if (r_grant_mem) begin
              r_mem_rsp_valid <= 1'b1;
              if (!r_is_write) begin
                r_mem_rsp_data <= ram_data_out;
              end else begin
                r_mem_rsp_data <= r_mem_rsp_data;
              end
            end else begin
              r_if_rsp_valid <= 1'b1;
              r_if_rsp_data  <= ram_data_out;
            end
          end else begin
            r_cnt <= r_cnt + ONE_C;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign if_req_ready     = w_if_ready;
  assign mem_req_ready    = w_mem_ready;
  assign if_rsp_valid     = r_if_rsp_valid;
  assign if_rsp_data      = r_if_rsp_data;
  assign mem_rsp_valid    = r_mem_rsp_valid;
  assign mem_rsp_data     = r_mem_rsp_data;
  assign ram_address      = r_ram_address;
  assign ram_data_in      = r_ram_data_in;
  assign ram_write_enable = r_ram_we;
  assign busy             = r_busy;
  assign grant_mem        = r_grant_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with RAM_LATENCY=1 and one with
// RAM_LATENCY=3 share the same requester stimulus. A schedule-based model
// (grant cycle, busy window, response cycle) predicts every output each cycle.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic if_v, mem_v, mem_we_i;
  logic [31:0] if_a, mem_a, mem_wd;

  logic        if_rdy [2];
  logic        mem_rdy[2];
  logic        if_rv  [2];
  logic        mem_rv [2];
  logic        we_o   [2];
  logic        busy_o [2];
  logic        gm_o   [2];
  logic [31:0] if_rd  [2];
  logic [31:0] mem_rd [2];
  logic [31:0] addr_o [2];
  logic [31:0] din_o  [2];
  logic [31:0] dout_i [2];

  // model state, per instance
  int          cyc;
  int          free_at[2];
  int          g_cyc  [2];
  bit          g_mem  [2];
  bit          g_we   [2];
  bit          any_g  [2];
  bit          last_mem[2];
  logic [31:0] g_addr [2];
  logic [31:0] g_wd   [2];
  logic [31:0] samp   [2];
  logic [31:0] e_if_d [2];
  logic [31:0] e_mem_d[2];
  logic [31:0] ram_m  [2][64];

  int checks;
  int errors;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_v), .if_req_ready(if_rdy[0]), .if_addr(if_a),
    .if_rsp_valid(if_rv[0]), .if_rsp_data(if_rd[0]),
    .mem_req_valid(mem_v), .mem_req_ready(mem_rdy[0]), .mem_addr(mem_a),
    .mem_wdata(mem_wd), .mem_we(mem_we_i),
    .mem_rsp_valid(mem_rv[0]), .mem_rsp_data(mem_rd[0]),
    .ram_address(addr_o[0]), .ram_data_in(din_o[0]), .ram_write_enable(we_o[0]),
    .ram_data_out(dout_i[0]), .busy(busy_o[0]), .grant_mem(gm_o[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_v), .if_req_ready(if_rdy[1]), .if_addr(if_a),
    .if_rsp_valid(if_rv[1]), .if_rsp_data(if_rd[1]),
    .mem_req_valid(mem_v), .mem_req_ready(mem_rdy[1]), .mem_addr(mem_a),
    .mem_wdata(mem_wd), .mem_we(mem_we_i),
    .mem_rsp_valid(mem_rv[1]), .mem_rsp_data(mem_rd[1]),
    .ram_address(addr_o[1]), .ram_data_in(din_o[1]), .ram_write_enable(we_o[1]),
    .ram_data_out(dout_i[1]), .busy(busy_o[1]), .grant_mem(gm_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Arbitration rule from the requester's point of view.
  function automatic bit pick_mem(input int k);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (if_v && mem_v) return !last_mem[k];
`endif
    return mem_v;
  endfunction

  task automatic chk(input int k, input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[L%0d] @cyc %0d: observed %h expected %h", tag, lat(k), cyc, got, exp);
    end
  endtask

  task automatic chk1(input int k, input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[L%0d] @cyc %0d: observed %b expected %b", tag, lat(k), cyc, got, exp);
    end
  endtask

  // Compare one instance against the schedule for the current cycle, then
  // record a handshake if one is due.
  task automatic check_inst(input int k);
    bit idle, pm, e_ifr, e_mr, rsp, e_we, e_busy;
    int L;
    L      = lat(k);
    idle   = (cyc >= free_at[k]);
    pm     = pick_mem(k);
    e_ifr  = idle && if_v && !pm;
    e_mr   = idle && mem_v && pm;
    e_we   = any_g[k] && (cyc == g_cyc[k] + 1) && g_we[k];
    e_busy = any_g[k] && (cyc >= g_cyc[k] + 1) && (cyc <= g_cyc[k] + L);
    rsp    = any_g[k] && (cyc == g_cyc[k] + L + 1);
    if (e_we) ram_m[k][g_addr[k][5:0]] = g_wd[k];
    if (rsp && !g_we[k]) begin
      if (g_mem[k]) e_mem_d[k] = samp[k];
      else          e_if_d[k]  = samp[k];
    end
    chk1(k, "if_req_ready",  if_rdy[k],  e_ifr);
    chk1(k, "mem_req_ready", mem_rdy[k], e_mr);
    chk1(k, "if_rsp_valid",  if_rv[k],   rsp && !g_mem[k]);
    chk1(k, "mem_rsp_valid", mem_rv[k],  rsp && g_mem[k]);
    chk (k, "if_rsp_data",   if_rd[k],   e_if_d[k]);
    chk (k, "mem_rsp_data",  mem_rd[k],  e_mem_d[k]);
    chk1(k, "ram_we",        we_o[k],    e_we);
    chk1(k, "busy",          busy_o[k],  e_busy);
    chk (k, "ram_address",   addr_o[k],  any_g[k] ? g_addr[k] : 32'h0);
    chk1(k, "grant_mem",     gm_o[k],    any_g[k] && g_mem[k]);
    if (e_we) chk(k, "ram_data_in", din_o[k], g_wd[k]);
    if (e_ifr || e_mr) begin
      any_g[k]    = 1'b1;
      g_cyc[k]    = cyc;
      g_mem[k]    = pm;
      g_we[k]     = pm && mem_we_i;
      g_addr[k]   = pm ? mem_a : if_a;
      g_wd[k]     = mem_wd;
      free_at[k]  = cyc + L + 1;
      last_mem[k] = pm;
    end
  endtask

  // One clock cycle: RAM model drives data only on the cycle it is valid.
  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      if (any_g[k] && (cyc == g_cyc[k] + lat(k)) && !g_we[k]) begin
        samp[k]   = ram_m[k][g_addr[k][5:0]];
        dout_i[k] = samp[k];
      end else begin
        dout_i[k] = $urandom();
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_inst(k);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    if_v  = 1'b0;
    mem_v = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Assert reset, check every output is zero at once, release after two edges.
  task automatic do_reset();
    rst   = 1'b0;
    if_v  = 1'b1;
    mem_v = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk1(k, "rst_if_req_ready",  if_rdy[k],  1'b0);
      chk1(k, "rst_mem_req_ready", mem_rdy[k], 1'b0);
      chk1(k, "rst_if_rsp_valid",  if_rv[k],   1'b0);
      chk1(k, "rst_mem_rsp_valid", mem_rv[k],  1'b0);
      chk (k, "rst_if_rsp_data",   if_rd[k],   32'h0);
      chk (k, "rst_mem_rsp_data",  mem_rd[k],  32'h0);
      chk (k, "rst_ram_address",   addr_o[k],  32'h0);
      chk (k, "rst_ram_data_in",   din_o[k],   32'h0);
      chk1(k, "rst_ram_we",        we_o[k],    1'b0);
      chk1(k, "rst_busy",          busy_o[k],  1'b0);
      chk1(k, "rst_grant_mem",     gm_o[k],    1'b0);
      any_g[k]    = 1'b0;
      e_if_d[k]   = 32'h0;
      e_mem_d[k]  = 32'h0;
      last_mem[k] = 1'b1;
    end
    if_v  = 1'b0;
    mem_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) free_at[k] = cyc;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    if_v = 1'b0; mem_v = 1'b0; mem_we_i = 1'b0;
    if_a = 32'h0; mem_a = 32'h0; mem_wd = 32'h0;
    for (int k = 0; k < 2; k++) begin
      dout_i[k] = 32'h0; samp[k] = 32'h0; g_cyc[k] = 0; g_mem[k] = 1'b0;
      g_we[k] = 1'b0; g_addr[k] = 32'h0; g_wd[k] = 32'h0;
      for (int i = 0; i < 64; i++) ram_m[k][i] = 32'hA500_0000 | 32'(i);
      ram_m[k][16] = 32'hDEAD_BEEF;
    end

    // power-on reset
    do_reset();

    // reset abandons an accepted access: no response after release
    if_v = 1'b1; if_a = 32'h10;
    cycle();
    chk1(0, "t1_busy_before_rst", busy_o[0], 1'b1);
    do_reset();
    idle_cycles(5);

    // L=1 IF read of 0x10 returns DEADBEEF two cycles after the handshake
    if_v = 1'b1; if_a = 32'h10;
    cycle();
    chk(0, "t2_ram_address", addr_o[0], 32'h10);
    if_v = 1'b0;
    cycle();
    chk1(0, "t2_if_rsp_valid", if_rv[0], 1'b1);
    chk (0, "t2_if_rsp_data",  if_rd[0], 32'hDEAD_BEEF);
    idle_cycles(4);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // fixed priority: MEM first, IF served right after MEM's response
    if_v = 1'b1; if_a = 32'h10; mem_v = 1'b1; mem_we_i = 1'b0; mem_a = 32'h24;
    cycle();
    chk1(0, "t3_grant_mem", gm_o[0], 1'b1);
    mem_v = 1'b0;
    cycle();
    #1;
    chk1(0, "t3_mem_rsp_valid", mem_rv[0], 1'b1);
    chk1(0, "t3_if_req_ready",  if_rdy[0], 1'b1);
    cycle();
    if_v = 1'b0;
    cycle();
    chk1(0, "t3_if_rsp_valid", if_rv[0], 1'b1);
    chk (0, "t3_if_rsp_data",  if_rd[0], 32'hDEAD_BEEF);
    idle_cycles(5);
`endif

    // continuous contention straight after reset
    do_reset();
    if_v = 1'b1; if_a = 32'h10; mem_v = 1'b1; mem_we_i = 1'b0; mem_a = 32'h24;
    for (int i = 0; i < 8; i++) begin
      #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk1(0, "t5_if_ready",  if_rdy[0],  (i % 4) == 0);
      chk1(0, "t5_mem_ready", mem_rdy[0], (i % 4) == 2);
`else
      chk1(0, "t5_if_ready",  if_rdy[0],  1'b0);
      chk1(0, "t5_mem_ready", mem_rdy[0], (i % 2) == 0);
`endif
      cycle();
    end
    idle_cycles(6);

    // MEM write then read back through the same port
    mem_v = 1'b1; mem_we_i = 1'b1; mem_a = 32'h20; mem_wd = 32'h0000_1234;
    cycle();
    chk1(0, "t4_we_t1",      we_o[0],  1'b1);
    chk (0, "t4_ram_din",    din_o[0], 32'h0000_1234);
    mem_v = 1'b0; mem_we_i = 1'b0;
    cycle();
    chk1(0, "t4_we_t2",      we_o[0],   1'b0);
    chk1(0, "t4_write_ack",  mem_rv[0], 1'b1);
    mem_v = 1'b1; mem_we_i = 1'b0; mem_a = 32'h20;
    cycle();
    mem_v = 1'b0;
    cycle();
    chk1(0, "t4_rd_valid", mem_rv[0], 1'b1);
    chk (0, "t4_rd_data",  mem_rd[0], 32'h0000_1234);
    idle_cycles(6);

    // L=3: ready low and busy high for three cycles, response on the fourth
    if_v = 1'b1; if_a = 32'h30;
    cycle();
    for (int j = 1; j <= 3; j++) begin
      #1;
      chk1(1, "t6_busy",     busy_o[1], 1'b1);
      chk1(1, "t6_if_ready", if_rdy[1], 1'b0);
      cycle();
    end
    #1;
    chk1(1, "t6_if_rsp_valid", if_rv[1],  1'b1);
    chk1(1, "t6_busy_done",    busy_o[1], 1'b0);
    if_v = 1'b0;
    idle_cycles(4);

    // randomized traffic with valids that may drop before being accepted
    for (int i = 0; i < 400; i++) begin
      if_v     = ($urandom_range(0, 3) != 0);
      mem_v    = ($urandom_range(0, 2) != 0);
      mem_we_i = $urandom_range(0, 1) == 1;
      if_a     = 32'($urandom_range(0, 63));
      mem_a    = 32'($urandom_range(0, 63));
      mem_wd   = $urandom();
      cycle();
    end
    idle_cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
